// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-bus slave for the rv32i core: byte-lane alignment, data
//               RAM, console/cycle/status MMIO page, optional wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DMEM_WORDS  = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_cmd_addr_i,
    input  logic        dbus_cmd_we_i,
    input  logic        dbus_cmd_valid_i,
    output logic        dbus_cmd_ack_o,
    output logic [31:0] dbus_read_data_o,
    input  logic [31:0] dbus_write_data_i,
    input  logic [3:0]  dbus_write_en_i,
    output logic        console_valid_o,
    output logic [7:0]  console_data_o,
    output logic        misalign_o
);

    localparam int         AW        = $clog2(DMEM_WORDS);
    localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_cnt;
    logic [31:0]   read_word;
    logic [31:0]   cycle_cnt;
    logic [31:0]   mem [DMEM_WORDS];

    logic          accept;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          is_mmio;
    logic [1:0]    mmio_sel;
    logic          size_legal;
    logic          store_ok;
    logic          store_bad;
    logic [3:0]    lane_mask;
    logic [31:0]   wdata_shift;
    logic [31:0]   mmio_rd;
    logic [31:0]   load_word;
    logic          unused_addr;

    assign off         = dbus_cmd_addr_i[1:0];
    assign idx         = dbus_cmd_addr_i[2 +: AW];
    assign is_mmio     = dbus_cmd_addr_i[31];
    assign mmio_sel    = dbus_cmd_addr_i[3:2];
    assign unused_addr = ^dbus_cmd_addr_i;

    // Reset wins over a request arriving in the same cycle.
    assign accept = (state == S_IDLE) && dbus_cmd_valid_i && !rst_i;

    always_comb begin
        size_legal = 1'b0;
        case (dbus_write_en_i)
            4'b0001: size_legal = 1'b1;
            4'b0011: size_legal = !off[0];
            4'b1111: size_legal = (off == 2'd0);
            default: size_legal = 1'b0;
        endcase
    end

    assign store_ok    = accept && dbus_cmd_we_i && size_legal;
    assign store_bad   = accept && dbus_cmd_we_i && !size_legal;
    assign lane_mask   = dbus_write_en_i << off;
    assign wdata_shift = dbus_write_data_i << {off, 3'b000};

    always_comb begin
        mmio_rd = 32'd0;
        case (mmio_sel)
            2'd1:    mmio_rd = cycle_cnt;
            2'd2:    mmio_rd = {31'd0, misalign_o};
            default: mmio_rd = 32'd0;
        endcase
    end

    assign load_word = is_mmio ? mmio_rd : (mem[idx] >> {off, 3'b000});

    // RAM has no reset; a write committed before a reset stays in memory.
    always_ff @(posedge clk_i) begin
        if (store_ok && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem[idx][8*i +: 8] <= wdata_shift[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (dbus_cmd_valid_i) state_next = HAS_WAIT ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt <= 4'd1) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt        <= 4'd0;
            read_word       <= 32'd0;
            cycle_cnt       <= 32'd0;
            misalign_o      <= 1'b0;
            console_valid_o <= 1'b0;
            console_data_o  <= 8'd0;
        end else begin
            cycle_cnt       <= cycle_cnt + 32'd1;
            console_valid_o <= store_ok && is_mmio && (mmio_sel == 2'd0);
            if (accept) begin
                wait_cnt  <= WAIT_INIT;
                read_word <= dbus_cmd_we_i ? 32'd0 : load_word;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (store_ok && is_mmio && (mmio_sel == 2'd0)) begin
                console_data_o <= dbus_write_data_i[7:0];
            end
            if (store_bad) begin
                misalign_o <= 1'b1;
            end else if (store_ok && is_mmio && (mmio_sel == 2'd2)) begin
                misalign_o <= 1'b0;
            end
        end
    end

    assign dbus_cmd_ack_o   = (state == S_RESP);
    assign dbus_read_data_o = dbus_cmd_ack_o ? read_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench with a byte-level memory/MMIO model, checking
//               two instances (no wait states and three wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic        valid [2];
    logic [31:0] wd    [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        cvalid[2];
    logic [7:0]  cdata [2];
    logic        mis   [2];

    dmem_responder #(.DMEM_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .dbus_cmd_addr_i(addr[0]), .dbus_cmd_we_i(we[0]),
        .dbus_cmd_valid_i(valid[0]), .dbus_cmd_ack_o(ack[0]), .dbus_read_data_o(rdata[0]),
        .dbus_write_data_i(wd[0]), .dbus_write_en_i(be[0]), .console_valid_o(cvalid[0]),
        .console_data_o(cdata[0]), .misalign_o(mis[0]));

    dmem_responder #(.DMEM_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .dbus_cmd_addr_i(addr[1]), .dbus_cmd_we_i(we[1]),
        .dbus_cmd_valid_i(valid[1]), .dbus_cmd_ack_o(ack[1]), .dbus_read_data_o(rdata[1]),
        .dbus_write_data_i(wd[1]), .dbus_write_en_i(be[1]), .console_valid_o(cvalid[1]),
        .console_data_o(cdata[1]), .misalign_o(mis[1]));

    int          edges = 0;
    int          last_rst   [2];
    int          exp_ack    [2];
    logic [31:0] exp_rd     [2];
    bit          exp_load   [2];
    int          cons_edge  [2];
    int          cons_pulses[2];
    logic [7:0]  m_cons     [2];
    logic        m_mis      [2];
    logic [7:0]  m_mem [int];
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        edges <= edges + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) last_rst[d] <= edges + 1;
        end
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic int key(input int d, input logic [31:0] a);
        return d * (1 << 20) + int'(a & 32'(4 * DEPTH - 1));
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a, input int e0);
        logic [31:0] base;
        logic [31:0] word;
        if (a[31]) begin
            if (a[3:2] == 2'd1) return 32'(e0 - last_rst[d]);
            if (a[3:2] == 2'd2) return {31'd0, m_mis[d]};
            return 32'd0;
        end
        base = {a[31:2], 2'b00};
        word = {m_mem[key(d, base + 3)], m_mem[key(d, base + 2)],
                m_mem[key(d, base + 1)], m_mem[key(d, base)]};
        return word >> (8 * int'(a[1:0]));
    endfunction

    task automatic model_store(input int d, input logic [31:0] a, input logic [31:0] data,
                               input logic [3:0] b, input int e0);
        int  n;
        bit  legal;
        n     = (b == 4'b0001) ? 1 : (b == 4'b0011) ? 2 : 4;
        legal = (b == 4'b0001) || (b == 4'b0011 && a[0] == 1'b0) ||
                (b == 4'b1111 && a[1:0] == 2'b00);
        if (!legal) begin
            m_mis[d] = 1'b1;
        end else if (a[31]) begin
            if (a[3:2] == 2'd0) begin
                m_cons[d]    = data[7:0];
                cons_edge[d] = e0 + 1;
            end else if (a[3:2] == 2'd2) begin
                m_mis[d] = 1'b0;
            end
        end else begin
            for (int i = 0; i < n; i++) m_mem[key(d, a + 32'(i))] = data[8*i +: 8];
        end
    endtask

    task automatic model_reset(input int d);
        m_mis[d]     = 1'b0;
        m_cons[d]    = 8'd0;
        cons_edge[d] = -1;
        exp_ack[d]   = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check(ack[d] === (edges == exp_ack[d]), "ack", 32'(ack[d]),
                      32'(edges == exp_ack[d]));
                if (edges != exp_ack[d])
                    check(rdata[d] === 32'd0, "rdata_idle", rdata[d], 32'd0);
                else if (exp_load[d])
                    check(rdata[d] === exp_rd[d], "rdata", rdata[d], exp_rd[d]);
                check(cvalid[d] === (edges == cons_edge[d]), "console_valid",
                      32'(cvalid[d]), 32'(edges == cons_edge[d]));
                check(cdata[d] === m_cons[d], "console_data", 32'(cdata[d]), 32'(m_cons[d]));
                check(mis[d] === m_mis[d], "misalign", 32'(mis[d]), 32'(m_mis[d]));
                if (cvalid[d] === 1'b1) cons_pulses[d] <= cons_pulses[d] + 1;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that leaves RESP.
    task automatic xact(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] b, input bit keep,
                        output logic [31:0] rd, output int ack_edge);
        int e0;
        int guard;
        addr[d] = a; we[d] = w; wd[d] = data; be[d] = b; valid[d] = 1'b1;
        e0          = edges;
        exp_load[d] = !w;
        exp_rd[d]   = w ? 32'd0 : model_load(d, a, e0);
        exp_ack[d]  = e0 + 1 + wait_of(d);
        @(posedge clk); #1;
        if (w) model_store(d, a, data, b, e0);
        guard = 0;
        while (edges < exp_ack[d] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check(ack[d] === 1'b1, "ack_latency", 32'(ack[d]), 32'd1);
        rd       = rdata[d];
        ack_edge = edges;
        @(posedge clk); #1;
        if (!keep) valid[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] rd, rd2;
    int          ae1, ae2, ae3, ae4, e0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; addr[d] = 32'd0; we[d] = 1'b0;
            wd[d] = 32'd0; be[d] = 4'd0; cons_pulses[d] = 0; exp_rd[d] = 32'd0;
            exp_load[d] = 1'b0; last_rst[d] = 0;
            model_reset(d);
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk_en = 1'b1;
        check(ack[0] === 1'b0 && rdata[0] === 32'd0, "reset_bus", rdata[0], 32'd0);
        check(mis[0] === 1'b0 && cdata[0] === 8'd0 && cvalid[0] === 1'b0, "reset_mmio",
              {cdata[0], 7'd0, cvalid[0], 15'd0, mis[0]}, 32'd0);

        // RAM lane alignment, no wait states
        xact(0, 1, 32'h100, 32'h1234_5678, 4'b1111, 0, rd, ae1);
        xact(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'h1234_5678, "lw_100", rd, 32'h1234_5678);
        xact(0, 1, 32'h103, 32'h0000_00AB, 4'b0001, 0, rd, ae1);
        xact(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'hAB34_5678, "sb_103", rd, 32'hAB34_5678);
        xact(0, 0, 32'h103, 32'h0, 4'b0001, 0, rd, ae1);
        check(rd === 32'h0000_00AB, "lbu_103", rd, 32'h0000_00AB);
        xact(0, 1, 32'h102, 32'h0000_BEEF, 4'b0011, 0, rd, ae1);
        xact(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'hBEEF_5678, "sh_102", rd, 32'hBEEF_5678);
        xact(0, 0, 32'h101, 32'h0, 4'b1111, 0, rd, ae1);
        check(rd === 32'h00BE_EF56, "lw_cross", rd, 32'h00BE_EF56);

        // Illegal stores, status register
        xact(0, 1, 32'h101, 32'h0000_1111, 4'b0011, 0, rd, ae1);
        xact(0, 1, 32'h102, 32'h2222_3333, 4'b1111, 0, rd, ae1);
        xact(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'hBEEF_5678 && mis[0] === 1'b1, "misalign_no_write", rd, 32'hBEEF_5678);
        xact(0, 0, 32'h8000_0008, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'd1, "status_set", rd, 32'd1);
        xact(0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 4'b1111, 0, rd, ae1);
        xact(0, 0, 32'h8000_000A, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'd0, "status_clear", rd, 32'd0);
        xact(0, 1, 32'h1100, 32'h5A5A_5A5A, 4'b1111, 0, rd, ae1);
        xact(0, 1, 32'h100, 32'h0000_00FF, 4'b0101, 0, rd, ae1);
        xact(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'h5A5A_5A5A && mis[0] === 1'b1, "alias_badsize", rd, 32'h5A5A_5A5A);
        xact(0, 1, 32'h8000_0008, 32'h0, 4'b0001, 0, rd, ae1);

        // Console, cycle counter, unmapped MMIO
        xact(0, 1, 32'h8000_0000, 32'h0000_0041, 4'b0001, 0, rd, ae1);
        check(cdata[0] === 8'h41 && cons_pulses[0] == 1, "console", 32'(cdata[0]), 32'h41);
        xact(0, 0, 32'h8000_0003, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'd0, "console_read", rd, 32'd0);
        xact(0, 0, 32'h8000_000C, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'd0, "unmapped_read", rd, 32'd0);
        xact(0, 0, 32'h8000_0004, 32'h0, 4'b0000, 0, rd, ae1);
        idle(10);
        xact(0, 0, 32'h8000_0004, 32'h0, 4'b0000, 0, rd2, ae1);
        check(rd2 - rd === 32'd12, "cycle_delta", rd2 - rd, 32'd12);

        // Three wait states, back-to-back with valid held
        xact(1, 1, 32'h200, 32'h1111_2222, 4'b1111, 1, rd, ae1);
        xact(1, 0, 32'h200, 32'h0, 4'b0000, 1, rd, ae2);
        check(rd === 32'h1111_2222, "wait_lw", rd, 32'h1111_2222);
        xact(1, 1, 32'h204, 32'h3333_4444, 4'b1111, 1, rd, ae3);
        xact(1, 0, 32'h204, 32'h0, 4'b0000, 0, rd, ae4);
        check(rd === 32'h3333_4444, "wait_lw2", rd, 32'h3333_4444);
        check(ae2 - ae1 == 5 && ae3 - ae2 == 5 && ae4 - ae3 == 5, "ack_period",
              32'(ae4 - ae1), 32'd15);

        // Reset while in WAIT: store persists, ack discarded, outputs cleared
        xact(1, 1, 32'h301, 32'h0000_7777, 4'b0011, 0, rd, ae1);
        addr[1] = 32'h300; we[1] = 1'b1; wd[1] = 32'hCAFE_F00D; be[1] = 4'b1111; valid[1] = 1'b1;
        e0 = edges;
        exp_load[1] = 1'b0;
        exp_ack[1]  = e0 + 4;
        @(posedge clk); #1;
        model_store(1, 32'h300, 32'hCAFE_F00D, 4'b1111, e0);
        @(posedge clk); #1;
        rst[1] = 1'b1; valid[1] = 1'b0;
        exp_ack[1] = -1;
        @(posedge clk); #1;
        model_reset(1);
        rst[1] = 1'b0;
        check(ack[1] === 1'b0 && rdata[1] === 32'd0, "rst_wait_bus", rdata[1], 32'd0);
        check(mis[1] === 1'b0, "rst_wait_misalign", 32'(mis[1]), 32'd0);
        idle(6);
        xact(1, 0, 32'h300, 32'h0, 4'b0000, 0, rd, ae1);
        check(rd === 32'hCAFE_F00D, "store_survives_reset", rd, 32'hCAFE_F00D);
        xact(1, 0, 32'h8000_0004, 32'h0, 4'b0000, 0, rd, ae1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
